// File: rtl/jpeg_mcu_sched.sv
// MCU scheduler and block-tag pipeline controller for the JPEG decoder.
// Walks the blocks of each MCU in sampling-mode order and tags them.
// Handles restart intervals and tracks each tag through a chain of
// downstream stages that shift forward as each stage finishes.
module jpeg_mcu_sched #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned XW     = 13,
    parameter int unsigned DIMW   = 16,
    localparam int unsigned TAGW  = 5 + 2 * XW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [DIMW-1:0]        width,
    input  logic [DIMW-1:0]        height,
    input  logic [15:0]            rst_intv,
    input  logic                   blk_done,
    output logic                   blk_req,
    output logic [1:0]             cur_comp,
    output logic [2:0]             cur_blk,
    output logic [XW-1:0]          cur_x,
    output logic [XW-1:0]          cur_y,
    output logic                   dc_reset,
    output logic                   rst_wait,
    input  logic                   rst_marker,
    input  logic [2:0]             rst_idx,
    input  logic [STAGES-1:0]      stg_done,
    output logic [STAGES-1:0]      stg_valid,
    output logic [STAGES*TAGW-1:0] stg_tag,
    output logic [XW-1:0]          mcu_w,
    output logic [XW-1:0]          mcu_h,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err
);

    // One spare bit so the round-up add cannot overflow
    localparam int unsigned EW = DIMW + 1;

    typedef enum logic [2:0] {StIdle, StDec, StRwait, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        mode_q;
    logic [15:0]       intv_q, rcnt_q, rcnt_inc;
    logic [XW-1:0]     mcu_w_q, mcu_h_q, x_q, y_q, mcu_w_new, mcu_h_new;
    logic [2:0]        blk_q, exp_idx_q, blk_last_idx;
    logic              err_q, dc_reset_q;
    logic [EW-1:0]     w_ext, h_ext;
    logic              start_ok, dim_zero, accept, last_blk, last_mcu, rst_hit;
    logic [TAGW-1:0]   cur_tag;
    logic [STAGES-1:0] valid_q, fin_q, fin_eff, move, in_valid;
    logic [TAGW-1:0]   tag_q  [STAGES];
    logic [TAGW-1:0]   in_tag [STAGES];

    // Block order within an MCU: last block index and component of current block
    always_comb begin
        blk_last_idx = 3'd0;
        cur_comp     = 2'd0;
        case (mode_q)
            2'd0: begin
                blk_last_idx = 3'd2;
                cur_comp     = blk_q[1:0];
            end
            2'd1: begin
                blk_last_idx = 3'd3;
                cur_comp     = (blk_q < 3'd2) ? 2'd0 : 2'(blk_q - 3'd1);
            end
            2'd2: begin
                blk_last_idx = 3'd5;
                cur_comp     = (blk_q < 3'd4) ? 2'd0 : 2'(blk_q - 3'd3);
            end
            default: begin
                blk_last_idx = 3'd0;
                cur_comp     = 2'd0;
            end
        endcase
    end

    // Frame geometry and progress decode
    always_comb begin
        w_ext     = {1'b0, width};
        h_ext     = {1'b0, height};
        mcu_w_new = (mode == 2'd1 || mode == 2'd2) ? XW'((w_ext + EW'(15)) >> 4)
                                                   : XW'((w_ext + EW'(7)) >> 3);
        mcu_h_new = (mode == 2'd2) ? XW'((h_ext + EW'(15)) >> 4)
                                   : XW'((h_ext + EW'(7)) >> 3);
        dim_zero  = (width == '0) || (height == '0);
        start_ok  = start && (state_q == StIdle);
        accept    = blk_done && blk_req;
        last_blk  = (blk_q == blk_last_idx);
        last_mcu  = last_blk && (x_q == mcu_w_q - XW'(1)) && (y_q == mcu_h_q - XW'(1));
        rcnt_inc  = rcnt_q + 16'd1;
        rst_hit   = (intv_q != 16'd0) && (rcnt_inc == intv_q);
        cur_tag   = {cur_comp, blk_q, x_q, y_q};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StIdle;
        else      state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !dim_zero) state_d = StDec;
            StDec: begin
                if (accept && last_blk) begin
                    if (last_mcu)     state_d = StDrain;
                    else if (rst_hit) state_d = StRwait;
                end
            end
            StRwait: if (rst_marker) state_d = StDec;
            StDrain: if (valid_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy       = (state_q != StIdle);
        rst_wait   = (state_q == StRwait);
        frame_done = (state_q == StDone);
        blk_req    = (state_q == StDec) && (!valid_q[0] || move[0]);
    end

    // Frame config, MCU walk, restart tracking and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= 2'd0;
            intv_q     <= 16'd0;
            mcu_w_q    <= '0;
            mcu_h_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            blk_q      <= 3'd0;
            rcnt_q     <= 16'd0;
            exp_idx_q  <= 3'd0;
            err_q      <= 1'b0;
            dc_reset_q <= 1'b0;
        end else begin
            dc_reset_q <= 1'b0;
            if (start_ok) begin
                if (dim_zero) begin
                    err_q <= 1'b1;
                end else begin
                    mode_q     <= mode;
                    intv_q     <= rst_intv;
                    mcu_w_q    <= mcu_w_new;
                    mcu_h_q    <= mcu_h_new;
                    x_q        <= '0;
                    y_q        <= '0;
                    blk_q      <= 3'd0;
                    rcnt_q     <= 16'd0;
                    exp_idx_q  <= 3'd0;
                    err_q      <= 1'b0;
                    dc_reset_q <= 1'b1;
                end
            end
            if (accept) begin
                if (last_blk) begin
                    blk_q  <= 3'd0;
                    rcnt_q <= rcnt_inc;
                    if (x_q == mcu_w_q - XW'(1)) begin
                        x_q <= '0;
                        y_q <= y_q + XW'(1);
                    end else begin
                        x_q <= x_q + XW'(1);
                    end
                end else begin
                    blk_q <= blk_q + 3'd1;
                end
            end
            // A marker outside the wait state is a stream error; inside it we
            // resync even when the index is wrong.
            if (rst_marker) begin
                if (state_q == StRwait) begin
                    if (rst_idx != exp_idx_q) err_q <= 1'b1;
                    rcnt_q     <= 16'd0;
                    exp_idx_q  <= exp_idx_q + 3'd1;
                    dc_reset_q <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Pipeline shift: a finished stage moves when its successor is empty or moving
    always_comb begin
        fin_eff = fin_q | (stg_done & valid_q);
        move    = '0;
        move[STAGES-1] = valid_q[STAGES-1] && fin_eff[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            move[k] = valid_q[k] && fin_eff[k] && (!valid_q[k+1] || move[k+1]);
        end
        in_valid[0] = accept;
        in_tag[0]   = cur_tag;
        for (int k = 1; k < STAGES; k++) begin
            in_valid[k] = move[k-1];
            in_tag[k]   = tag_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            stg_tag[k*TAGW +: TAGW] = tag_q[k];
        end
    end

    // Pipeline stage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            fin_q   <= '0;
            for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (in_valid[k]) begin
                    valid_q[k] <= 1'b1;
                    fin_q[k]   <= 1'b0;
                    tag_q[k]   <= in_tag[k];
                end else if (move[k]) begin
                    valid_q[k] <= 1'b0;
                    fin_q[k]   <= 1'b0;
                end else begin
                    fin_q[k]   <= fin_eff[k];
                end
            end
        end
    end

    assign stg_valid = valid_q;
    assign cur_blk   = blk_q;
    assign cur_x     = x_q;
    assign cur_y     = y_q;
    assign mcu_w     = mcu_w_q;
    assign mcu_h     = mcu_h_q;
    assign dc_reset  = dc_reset_q;
    assign err       = err_q;

endmodule
